// File: rtl/tx_xgmii_framer_pkg.sv
// Shared XGMII TX framer definitions: control characters, FIFO status
// byte layout and the framer state encoding.
package tx_xgmii_framer_pkg;

  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_ERROR    = 8'hFE;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  localparam int unsigned STAT_SOP    = 7;
  localparam int unsigned STAT_EOP    = 6;
  localparam int unsigned STAT_CNT_HI = 2;
  localparam int unsigned STAT_CNT_LO = 0;

  localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
  localparam logic [63:0] ERROR_WORD    = {8{XGMII_ERROR}};
  localparam logic [63:0] PREAMBLE_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DROP,
    ST_IFG
  } state_t;

endpackage

// File: rtl/tx_xgmii_framer_if.sv
// TX FIFO read side plus XGMII TX bus, as seen by the framer.
interface tx_xgmii_framer_if;

  logic [63:0] txdfifo_rdata;
  logic [7:0]  txdfifo_rstatus;
  logic        txdfifo_rempty;
  logic        txdfifo_ralmost_empty;
  logic        txdfifo_ren;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;

  // Framer side: consumes FIFO data, drives the pop and the XGMII bus.
  modport master (
    input  txdfifo_rdata, txdfifo_rstatus, txdfifo_rempty, txdfifo_ralmost_empty,
    output txdfifo_ren, xgmii_txd, xgmii_txc
  );

  // FIFO / PHY side.
  modport slave (
    output txdfifo_rdata, txdfifo_rstatus, txdfifo_rempty, txdfifo_ralmost_empty,
    input  txdfifo_ren, xgmii_txd, xgmii_txc
  );

endinterface

// File: rtl/tx_xgmii_term_mux.sv
// Builds the XGMII word that carries Terminate: the first nbytes lanes keep
// data (0 means all 8), the next lane is FD, the rest are Idle. term_only
// produces the stand-alone FD,07x7 word that follows a full 8-byte EOP word.
module tx_xgmii_term_mux
  import tx_xgmii_framer_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  nbytes,
  input  logic        term_only,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  logic [3:0] n;

  assign n = (nbytes == 3'd0) ? 4'd8 : {1'b0, nbytes};

  for (genvar g = 0; g < 8; g++) begin : g_lane
    localparam logic [3:0] LANE = 4'(g);
    assign txd[8*g +: 8] = term_only   ? ((g == 0) ? XGMII_TERM : XGMII_IDLE) :
                           (LANE < n)  ? data[8*g +: 8] :
                           (LANE == n) ? XGMII_TERM : XGMII_IDLE;
    assign txc[g] = term_only | (LANE >= n);
  end

endmodule

// File: rtl/tx_xgmii_framer.sv
// XGMII TX framer: pops words from the TX data FIFO and emits
// Start/preamble, data, Terminate and the inter-frame gap; a mid-frame
// underrun yields an Error word and the rest of the frame is discarded.
module tx_xgmii_framer
  import tx_xgmii_framer_pkg::*;
#(
  parameter int unsigned IFG_WORDS             = 2,
  parameter bit          START_ON_ALMOST_EMPTY = 1'b1
) (
  input  logic              clk_xgmii_tx,
  input  logic              reset_xgmii_tx_n,
  input  logic              ctrl_tx_enable,
  tx_xgmii_framer_if.master bus,
  output logic              status_txdfifo_udflow
);

  state_t      state;
  logic        rd_valid;
  logic        first_word;
  logic        term_pend;
  logic [3:0]  ifg_cnt;
  logic        ren_int;
  logic        start;
  logic        sop;
  logic        eop;
  logic [2:0]  nbytes;
  logic [63:0] term_txd;
  logic [7:0]  term_txc;
  logic        unused_status;

  assign sop           = bus.txdfifo_rstatus[STAT_SOP];
  assign eop           = bus.txdfifo_rstatus[STAT_EOP];
  assign nbytes        = bus.txdfifo_rstatus[STAT_CNT_HI:STAT_CNT_LO];
  assign unused_status = ^bus.txdfifo_rstatus[5:3];

  assign start = ctrl_tx_enable &
                 (START_ON_ALMOST_EMPTY ? ~bus.txdfifo_ralmost_empty : ~bus.txdfifo_rempty);

  // FIFO pop: never reads past an EOP word that is currently on rdata.
  always_comb begin
    ren_int = 1'b0;
    unique case (state)
      ST_IDLE: ren_int = start;
      ST_DATA: ren_int = rd_valid & ~eop & ~bus.txdfifo_rempty & ~term_pend;
      ST_DROP: ren_int = ~bus.txdfifo_rempty & ~(rd_valid & eop);
      ST_IFG:  ren_int = 1'b0;
    endcase
  end

  // Gated by reset so the pop drops immediately on asynchronous reset.
  assign bus.txdfifo_ren = ren_int & reset_xgmii_tx_n;

  tx_xgmii_term_mux u_term_mux (
    .data      (bus.txdfifo_rdata),
    .nbytes    (nbytes),
    .term_only (term_pend),
    .txd       (term_txd),
    .txc       (term_txc)
  );

  // Framing FSM with registered XGMII outputs and underflow pulse.
  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      state                 <= ST_IDLE;
      rd_valid              <= 1'b0;
      first_word            <= 1'b0;
      term_pend             <= 1'b0;
      ifg_cnt               <= '0;
      bus.xgmii_txd         <= IDLE_WORD;
      bus.xgmii_txc         <= '1;
      status_txdfifo_udflow <= 1'b0;
    end else begin
      rd_valid              <= ren_int;
      status_txdfifo_udflow <= 1'b0;
      bus.xgmii_txd         <= IDLE_WORD;
      bus.xgmii_txc         <= '1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bus.xgmii_txd <= PREAMBLE_WORD;
            bus.xgmii_txc <= 8'h01;
            first_word    <= 1'b1;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (term_pend) begin
            bus.xgmii_txd <= term_txd;
            bus.xgmii_txc <= term_txc;
            term_pend     <= 1'b0;
            ifg_cnt       <= 4'(IFG_WORDS);
            state         <= ST_IFG;
          end else if (!rd_valid) begin
            bus.xgmii_txd         <= ERROR_WORD;
            bus.xgmii_txc         <= '1;
            status_txdfifo_udflow <= 1'b1;
            state                 <= ST_DROP;
          end else if (sop && !first_word) begin
            bus.xgmii_txd <= ERROR_WORD;
            bus.xgmii_txc <= '1;
            state         <= ST_DROP;
          end else begin
            first_word <= 1'b0;
            if (!eop) begin
              bus.xgmii_txd <= bus.txdfifo_rdata;
              bus.xgmii_txc <= '0;
            end else begin
              // A full 8-byte EOP word passes through the mux unchanged;
              // its Terminate goes out on the next cycle via term_pend.
              bus.xgmii_txd <= term_txd;
              bus.xgmii_txc <= term_txc;
              if (nbytes == 3'd0) begin
                term_pend <= 1'b1;
              end else begin
                ifg_cnt <= 4'(IFG_WORDS);
                state   <= ST_IFG;
              end
            end
          end
        end
        ST_DROP: begin
          if (rd_valid && eop) begin
            ifg_cnt <= 4'(IFG_WORDS);
            state   <= ST_IFG;
          end
        end
        ST_IFG: begin
          ifg_cnt <= ifg_cnt - 4'd1;
          if (ifg_cnt <= 4'd1) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_xgmii_framer.sv
// Bench for tx_xgmii_framer: a queue-based FIFO model feeds random frames;
// the expected XGMII stream is built from each frame's byte sequence as a
// lane-ordered character stream (Start/preamble, bytes, Terminate, Idle pad).
module tb_tx_xgmii_framer;

  localparam int unsigned IFG = 2;
  localparam logic [71:0] IDLE_X = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] PRE_X  = {8'h01, 64'hD5555555555555FB};

  typedef struct packed {
    logic [7:0]  st;
    logic [63:0] d;
  } fent_t;

  logic clk;
  logic rst_n;
  logic enable;
  logic udflow;

  tx_xgmii_framer_if bus ();

  tx_xgmii_framer #(
    .IFG_WORDS             (IFG),
    .START_ON_ALMOST_EMPTY (1'b1)
  ) dut (
    .clk_xgmii_tx          (clk),
    .reset_xgmii_tx_n      (rst_n),
    .ctrl_tx_enable        (enable),
    .bus                   (bus),
    .status_txdfifo_udflow (udflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  fent_t       fifo_q[$];
  fent_t       stage_q[$];
  logic [7:0]  cur_fb[$];
  logic [8:0]  ch_q[$];
  logic [71:0] exp_q[$];
  logic [71:0] obs_q[$];
  int unsigned gap_q[$];

  int unsigned idle_run = 0;
  bit          have_prev = 0;
  int unsigned uf_pulses = 0;
  int unsigned uf_high = 0;
  bit          uf_prev = 0;
  int unsigned illegal_pops = 0;
  int unsigned ren_cycles = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic update_flags();
    bus.txdfifo_rempty        = (fifo_q.size() == 0);
    bus.txdfifo_ralmost_empty = (fifo_q.size() < 3);
  endtask

  task automatic monitor();
    logic [71:0] w;
    w = {bus.xgmii_txc, bus.xgmii_txd};
    if (udflow) begin
      uf_high++;
      if (!uf_prev) uf_pulses++;
    end
    uf_prev = udflow;
    if (w == IDLE_X) begin
      idle_run++;
    end else begin
      if (w == PRE_X && have_prev) gap_q.push_back(idle_run);
      have_prev = 1;
      idle_run  = 0;
      obs_q.push_back(w);
    end
  endtask

  // One clock: sample at negedge, then apply the pop to the FIFO model.
  task automatic step();
    logic  pop;
    fent_t e;
    @(negedge clk);
    pop = bus.txdfifo_ren;
    if (pop) ren_cycles++;
    monitor();
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() == 0) begin
      illegal_pops++;
    end else if (pop) begin
      e = fifo_q.pop_front();
      bus.txdfifo_rdata   = e.d;
      bus.txdfifo_rstatus = e.st;
    end else begin
      bus.txdfifo_rdata   = {$urandom, $urandom};
      bus.txdfifo_rstatus = 8'($urandom);
    end
    update_flags();
  endtask

  task automatic make_frame(input int unsigned len);
    cur_fb.delete();
    for (int unsigned i = 0; i < len; i++) cur_fb.push_back(8'($urandom));
  endtask

  // Pack cur_fb into FIFO words with SOP/EOP/count; unused status bits random.
  task automatic stage_frame();
    int unsigned n;
    int unsigned nw;
    int unsigned idx;
    logic [63:0] d;
    logic [7:0]  st;
    fent_t       e;
    n  = cur_fb.size();
    nw = (n + 7) / 8;
    for (int unsigned w = 0; w < nw; w++) begin
      d = '0;
      for (int unsigned b = 0; b < 8; b++) begin
        idx = w * 8 + b;
        d = {(idx < n) ? cur_fb[idx] : 8'($urandom), d[63:8]};
      end
      st    = 8'($urandom);
      st[7] = (w == 0);
      st[6] = (w == nw - 1);
      if (w == nw - 1) st[2:0] = 3'(n % 8);
      e.d  = d;
      e.st = st;
      stage_q.push_back(e);
    end
  endtask

  task automatic feed(input int unsigned k);
    repeat (k) fifo_q.push_back(stage_q.pop_front());
    update_flags();
  endtask

  task automatic add_preamble();
    ch_q.push_back({1'b1, 8'hFB});
    repeat (6) ch_q.push_back({1'b0, 8'h55});
    ch_q.push_back({1'b0, 8'hD5});
  endtask

  task automatic flush_chars();
    logic [63:0] w;
    logic [7:0]  c;
    logic [8:0]  e;
    while (ch_q.size() >= 8) begin
      w = '0;
      c = '0;
      for (int unsigned i = 0; i < 8; i++) begin
        e = ch_q.pop_front();
        w = {e[7:0], w[63:8]};
        c = {e[8], c[7:1]};
      end
      exp_q.push_back({c, w});
    end
  endtask

  task automatic expect_frame();
    add_preamble();
    foreach (cur_fb[i]) ch_q.push_back({1'b0, cur_fb[i]});
    ch_q.push_back({1'b1, 8'hFD});
    while (ch_q.size() % 8 != 0) ch_q.push_back({1'b1, 8'h07});
    flush_chars();
  endtask

  task automatic compare_streams(input string tag);
    chk({tag, "_len"}, 72'(obs_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until_drained(input string tag);
    int unsigned n;
    n = 0;
    while ((fifo_q.size() != 0 || obs_q.size() < exp_q.size()) && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 72'(n < 3000), 72'(1));
    repeat (8) step();
  endtask

  initial begin
    int unsigned n;
    rst_n   = 1'b0;
    enable  = 1'b0;
    bus.txdfifo_rdata   = '0;
    bus.txdfifo_rstatus = '0;
    update_flags();

    // Reset values
    repeat (3) step();
    chk("rst_txd", 72'(bus.xgmii_txd), 72'(64'h0707070707070707));
    chk("rst_txc", 72'(bus.xgmii_txc), 72'(8'hFF));
    chk("rst_ren", 72'(bus.txdfifo_ren), 72'(0));
    chk("rst_udflow", 72'(udflow), 72'(0));
    rst_n = 1'b1;
    repeat (2) step();

    // Back-to-back frames preloaded while disabled: count 4, count 0, two random
    make_frame(60);  stage_frame(); expect_frame();
    make_frame(64);  stage_frame(); expect_frame();
    make_frame($urandom_range(64, 130)); stage_frame(); expect_frame();
    make_frame($urandom_range(64, 130)); stage_frame(); expect_frame();
    feed(stage_q.size());
    repeat (12) step();
    chk("disabled_ren", 72'(ren_cycles), 72'(0));
    chk("disabled_out", 72'(obs_q.size()), 72'(0));
    enable = 1'b1;
    #1;
    chk("start_ren", 72'(bus.txdfifo_ren), 72'(1));
    step();
    step();
    chk("start_latency", 72'(obs_q.size()), 72'(1));
    run_until_drained("b2b");
    compare_streams("b2b");
    chk("b2b_gaps", 72'(gap_q.size()), 72'(3));
    foreach (gap_q[i]) chk($sformatf("b2b_gap%0d", i), 72'(gap_q[i]), 72'(IFG));
    chk("b2b_illegal_pop", 72'(illegal_pops), 72'(0));
    chk("b2b_no_udflow", 72'(uf_pulses), 72'(0));

    // Underrun after word 3 of a 10-word frame
    gap_q.delete();
    have_prev = 0;
    make_frame($urandom_range(73, 80));
    stage_frame();
    add_preamble();
    for (int unsigned i = 0; i < 24; i++) ch_q.push_back({1'b0, cur_fb[i]});
    repeat (8) ch_q.push_back({1'b1, 8'hFE});
    flush_chars();
    feed(3);
    n = 0;
    while (uf_pulses == 0 && n < 200) begin
      step();
      n++;
    end
    chk("ud_timeout", 72'(n < 200), 72'(1));
    feed(stage_q.size());
    run_until_drained("ud");
    compare_streams("ud");
    chk("ud_pulses", 72'(uf_pulses), 72'(1));
    chk("ud_width", 72'(uf_high), 72'(1));
    chk("ud_flushed", 72'(fifo_q.size()), 72'(0));
    chk("ud_illegal_pop", 72'(illegal_pops), 72'(0));

    // Asynchronous reset in the middle of a frame
    make_frame($urandom_range(80, 130));
    stage_frame();
    feed(stage_q.size());
    n = 0;
    while (obs_q.size() < 4 && n < 200) begin
      step();
      n++;
    end
    chk("rstmid_timeout", 72'(n < 200), 72'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_txd", 72'(bus.xgmii_txd), 72'(64'h0707070707070707));
    chk("rstmid_txc", 72'(bus.xgmii_txc), 72'(8'hFF));
    chk("rstmid_ren", 72'(bus.txdfifo_ren), 72'(0));
    fifo_q.delete();
    update_flags();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_txd", 72'(bus.xgmii_txd), 72'(64'h0707070707070707));
    obs_q.delete();
    exp_q.delete();
    gap_q.delete();
    have_prev = 0;

    // Framer returns to IDLE and frames a fresh random frame
    make_frame($urandom_range(64, 130));
    stage_frame();
    expect_frame();
    feed(stage_q.size());
    run_until_drained("after_rst");
    compare_streams("after_rst");
    chk("final_illegal_pop", 72'(illegal_pops), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
